// File: rtl/ascon_aead128_pkg.sv
// Shared Ascon types, tables and helpers.
// Used by the permutation engine and its round datapath.
package ascon_aead128_pkg;

  typedef struct packed {
    logic [63:0] s0;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] s3;
    logic [63:0] s4;
  } ascon_state;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } perm_fsm_e;

  localparam int MAX_ROUNDS = 12;

  // Column value {s0,s1,s2,s3,s4} with s0 as MSB
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  function automatic logic [7:0] rc(input logic [3:0] i);
    return {4'hf - i, i};
  endfunction

  function automatic logic [63:0] ror(
    input logic [63:0] x,
    input int          n
  );
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant, S-box layer, diffusion.
// Disabled stages forward the state untouched.
module ascon_round
  import ascon_aead128_pkg::*;
(
  input  ascon_state  state_i,
  input  logic [3:0]  idx_i,
  input  logic        en_i,
  output ascon_state  state_o
);

  logic [63:0] x [5];
  logic [63:0] y [5];
  logic [63:0] z [5];

  assign x[0] = state_i.s0;
  assign x[1] = state_i.s1;
  assign x[2] = state_i.s2 ^ {56'h0, rc(idx_i)};
  assign x[3] = state_i.s3;
  assign x[4] = state_i.s4;

  for (genvar b = 0; b < 64; b++) begin : g_col
    logic [4:0] sv;
    assign sv = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
    assign y[0][b] = sv[4];
    assign y[1][b] = sv[3];
    assign y[2][b] = sv[2];
    assign y[3][b] = sv[1];
    assign y[4][b] = sv[0];
  end

  for (genvar w = 0; w < 5; w++) begin : g_lin
    assign z[w] = y[w] ^ ror(y[w], ROT_A[w]) ^ ror(y[w], ROT_B[w]);
  end

  assign state_o = en_i ? {z[0], z[1], z[2], z[3], z[4]} : state_i;

endmodule

// File: rtl/permutation_engine.sv
// Iterative Ascon permutation, UNROLL rounds per clock.
// Handshaked request/result; out_state is the state register.
module permutation_engine
  import ascon_aead128_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  ascon_state  in_state,
  input  logic [3:0]  in_rounds,
  output logic        out_valid,
  input  logic        out_ready,
  output ascon_state  out_state
);

  perm_fsm_e   st_q, st_d;
  ascon_state  state_q, state_d;
  logic [3:0]  rem_q, rem_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  nr;
  ascon_state  chain [UNROLL+1];

  assign chain[0] = state_q;

  // Stages beyond the remaining count bypass
  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    ascon_round u_rnd (
      .state_i (chain[j]),
      .idx_i   (idx_q + 4'(j)),
      .en_i    (4'(j) < rem_q),
      .state_o (chain[j+1])
    );
  end

  assign nr = (in_rounds > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : in_rounds;

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    unique case (st_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in_state;
          if (nr == 4'd0) begin
            st_d = DONE;
          end else begin
            st_d  = RUN;
            rem_d = nr;
            idx_d = 4'(MAX_ROUNDS) - nr;
          end
        end
      end
      RUN: begin
        state_d = chain[UNROLL];
        idx_d   = idx_q + 4'(UNROLL);
        if (rem_q <= 4'(UNROLL)) begin
          st_d  = DONE;
          rem_d = 4'd0;
        end else begin
          rem_d = rem_q - 4'(UNROLL);
        end
      end
      DONE: begin
        if (out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      state_q <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (st_q == IDLE);
  assign out_valid = (st_q == DONE);
  assign out_state = state_q;

endmodule
